// File: rtl/sine_sweep_pkg.sv
// ---------------------------------------------------------------------------
// sine_sweep_pkg
// Shared types and default widths for the stepped-frequency sweep sequencer.
//   sweep_state_e : controller FSM states (IDLE, SWEEP, DONE)
//   sweep_dir_e   : sweep direction (UP, DOWN)
//   DEFAULT_PHASE_STEP_WIDTH / DEFAULT_DWELL_WIDTH : default parameter values
// ---------------------------------------------------------------------------
package sine_sweep_pkg;

  localparam int DEFAULT_PHASE_STEP_WIDTH = 32;
  localparam int DEFAULT_DWELL_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweep_dir_e;

endpackage

// File: rtl/sine_sweep_step_calc.sv
// ---------------------------------------------------------------------------
// sine_sweep_step_calc
// Combinational next-step computation for the sweep controller.
// The step moves toward stop_step by increment; it lands exactly on
// stop_step when the increment would reach or pass it, or when the
// increment is zero, so the sweep can never overshoot or wrap.
// Ports:
//   cur_step   in  current phase step
//   stop_step  in  final phase step
//   increment  in  unsigned step magnitude
//   direction  in  DIR_UP / DIR_DOWN
//   next_step  out next phase step
// ---------------------------------------------------------------------------
module sine_sweep_step_calc
  import sine_sweep_pkg::*;
#(
  parameter int PHASE_STEP_WIDTH = DEFAULT_PHASE_STEP_WIDTH
) (
  input  logic [PHASE_STEP_WIDTH-1:0] cur_step,
  input  logic [PHASE_STEP_WIDTH-1:0] stop_step,
  input  logic [PHASE_STEP_WIDTH-1:0] increment,
  input  sweep_dir_e                  direction,
  output logic [PHASE_STEP_WIDTH-1:0] next_step
);

  logic [PHASE_STEP_WIDTH-1:0] remaining_s;

  // Distance left to stop, then clamp-or-advance decision.
  always_comb begin
    remaining_s = {PHASE_STEP_WIDTH{1'b0}};
    next_step   = stop_step;
    if (direction == DIR_DOWN) begin
      remaining_s = cur_step - stop_step;
    end else begin
      remaining_s = stop_step - cur_step;
    end
    if ((increment == {PHASE_STEP_WIDTH{1'b0}}) || (increment >= remaining_s)) begin
      next_step = stop_step;
    end else if (direction == DIR_DOWN) begin
      next_step = cur_step - increment;
    end else begin
      next_step = cur_step + increment;
    end
  end

endmodule

// File: rtl/sine_sweep_controller.sv
// ---------------------------------------------------------------------------
// sine_sweep_controller
// Stepped-frequency sweep sequencer driving the sine generator phase_step.
// On start (in IDLE) the sweep configuration is latched and phase_step walks
// from start_step to stop_step, each step held for dwell_cycles+1 clocks,
// followed by a single DONE cycle. abort returns everything to IDLE with
// phase_step cleared.
// Build option: define SINE_SWEEP_LOOP_EN to make DONE restart the sweep
// from the latched start_step, repeating until abort.
// Ports:
//   clock          in  system clock
//   reset_n        in  asynchronous active-low reset
//   start          in  launches a sweep (sampled in IDLE only)
//   abort          in  terminates any sweep, wins over start
//   start_step     in  first phase step
//   stop_step      in  final phase step
//   step_increment in  step magnitude
//   dwell_cycles   in  hold count per step (held dwell_cycles+1 clocks)
//   phase_step     out registered phase step to the generator
//   sweep_busy     out high in SWEEP and DONE
//   sweep_done     out one-cycle pulse in DONE
// ---------------------------------------------------------------------------
module sine_sweep_controller
  import sine_sweep_pkg::*;
#(
  parameter int PHASE_STEP_WIDTH = DEFAULT_PHASE_STEP_WIDTH,
  parameter int DWELL_WIDTH      = DEFAULT_DWELL_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PHASE_STEP_WIDTH-1:0] start_step,
  input  logic [PHASE_STEP_WIDTH-1:0] stop_step,
  input  logic [PHASE_STEP_WIDTH-1:0] step_increment,
  input  logic [DWELL_WIDTH-1:0]      dwell_cycles,
  output logic [PHASE_STEP_WIDTH-1:0] phase_step,
  output logic                        sweep_busy,
  output logic                        sweep_done
);

  localparam logic [PHASE_STEP_WIDTH-1:0] PS_ZERO = {PHASE_STEP_WIDTH{1'b0}};
  localparam logic [DWELL_WIDTH-1:0]      DW_ZERO = {DWELL_WIDTH{1'b0}};
  localparam logic [DWELL_WIDTH-1:0]      DW_ONE  = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  sweep_state_e                state_r, state_next_s;
  logic [PHASE_STEP_WIDTH-1:0] phase_r, phase_next_s;
  logic [DWELL_WIDTH-1:0]      cnt_r, cnt_next_s;
  logic [PHASE_STEP_WIDTH-1:0] stop_r, stop_next_s;
  logic [PHASE_STEP_WIDTH-1:0] inc_r, inc_next_s;
  logic [DWELL_WIDTH-1:0]      dwell_r, dwell_next_s;
  sweep_dir_e                  dir_r, dir_next_s;
  logic                        busy_r, busy_next_s;
  logic                        done_r, done_next_s;
  logic [PHASE_STEP_WIDTH-1:0] step_next_s;
`ifdef SINE_SWEEP_LOOP_EN
  logic [PHASE_STEP_WIDTH-1:0] start_r, start_next_s;
`endif

  sine_sweep_step_calc #(
    .PHASE_STEP_WIDTH (PHASE_STEP_WIDTH)
  ) u_step_calc (
    .cur_step  (phase_r),
    .stop_step (stop_r),
    .increment (inc_r),
    .direction (dir_r),
    .next_step (step_next_s)
  );

  // State and datapath registers; outputs are registered copies of next values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      phase_r <= PS_ZERO;
      cnt_r   <= DW_ZERO;
      stop_r  <= PS_ZERO;
      inc_r   <= PS_ZERO;
      dwell_r <= DW_ZERO;
      dir_r   <= DIR_UP;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SINE_SWEEP_LOOP_EN
      start_r <= PS_ZERO;
`endif
    end else begin
      state_r <= state_next_s;
      phase_r <= phase_next_s;
      cnt_r   <= cnt_next_s;
      stop_r  <= stop_next_s;
      inc_r   <= inc_next_s;
      dwell_r <= dwell_next_s;
      dir_r   <= dir_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
`ifdef SINE_SWEEP_LOOP_EN
      start_r <= start_next_s;
`endif
    end
  end

  // Next-state and next-datapath logic; abort overrides every state.
  always_comb begin
    state_next_s = state_r;
    phase_next_s = phase_r;
    cnt_next_s   = cnt_r;
    stop_next_s  = stop_r;
    inc_next_s   = inc_r;
    dwell_next_s = dwell_r;
    dir_next_s   = dir_r;
`ifdef SINE_SWEEP_LOOP_EN
    start_next_s = start_r;
`endif
    if (abort) begin
      state_next_s = ST_IDLE;
      phase_next_s = PS_ZERO;
      cnt_next_s   = DW_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_next_s = ST_SWEEP;
            stop_next_s  = stop_step;
            inc_next_s   = step_increment;
            dwell_next_s = dwell_cycles;
            dir_next_s   = (start_step > stop_step) ? DIR_DOWN : DIR_UP;
            phase_next_s = start_step;
            cnt_next_s   = dwell_cycles;
`ifdef SINE_SWEEP_LOOP_EN
            start_next_s = start_step;
`endif
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (cnt_r != DW_ZERO) begin
            cnt_next_s = cnt_r - DW_ONE;
          end else if (phase_r == stop_r) begin
            state_next_s = ST_DONE;
          end else begin
            phase_next_s = step_next_s;
            cnt_next_s   = dwell_r;
          end
        end
        ST_DONE: begin
`ifdef SINE_SWEEP_LOOP_EN
          state_next_s = ST_SWEEP;
          phase_next_s = start_r;
          cnt_next_s   = dwell_r;
`else
          state_next_s = ST_IDLE;
`endif
        end
        default: begin
          state_next_s = ST_IDLE;
          phase_next_s = PS_ZERO;
          cnt_next_s   = DW_ZERO;
        end
      endcase
    end
    busy_next_s = (state_next_s != ST_IDLE);
    done_next_s = (state_next_s == ST_DONE);
  end

  assign phase_step = phase_r;
  assign sweep_busy = busy_r;
  assign sweep_done = done_r;

endmodule
